// File: rtl/band_power_calc.sv
// band_power_calc: per-band power engine for the spectrum bar display.
// Three signed sample streams are squared and accumulated every sample clock.
// A display flag closes the window: each accumulator is snapshotted and cleared.
// A shared bit-serial square root then turns each band's mean square into a
// 12-bit RMS bar height. Bands are processed in order 1, 2, 3.
module band_power_calc #(
   parameter int unsigned ACC_SHIFT = 12
) (
   input  logic        sample_clk,
   input  logic        rst_n,
   input  logic [11:0] band1_in,
   input  logic [11:0] band2_in,
   input  logic [11:0] band3_in,
   input  logic        set_values_flag,
   output logic [11:0] bin1_out,
   output logic [11:0] bin2_out,
   output logic [11:0] bin3_out,
   output logic        values_valid,
   output logic        busy,
   output logic [7:0]  overrun_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SQRT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Pipeline stage 1 / 2
   logic [11:0] r_s1_smp [3];
   logic        r_s1_flag;
   logic [11:0] w_mag    [3];
   logic [22:0] w_sq     [3];
   logic [22:0] r_s2_sq  [3];
   logic        r_s2_flag;

   // Accumulation and mean square
   logic [39:0] r_acc      [3];
   logic [40:0] w_sum      [3];
   logic [39:0] w_acc_next [3];
   logic [39:0] w_shifted  [3];
   logic [23:0] w_ms       [3];
   logic        w_snap;

   // Working / pending mean squares
   logic [23:0] r_work [3];
   logic [23:0] r_pend [3];
   logic        r_pending;
   logic [7:0]  r_overrun;

   // Square-root engine
   state_t      r_state;
   state_t      w_state_next;
   logic [1:0]  r_band;
   logic [3:0]  r_bit;
   logic [11:0] r_root;
   logic [23:0] r_root_sq;
   logic [11:0] r_res [3];
   logic [23:0] w_cur_ms;
   logic [11:0] w_bit_mask;
   logic [23:0] w_trial_sq;
   logic        w_take;
   logic [11:0] w_root_new;
   logic [23:0] w_root_sq_new;

   // Outputs
   logic [11:0] r_bin [3];
   logic        r_vv;

   // Stage 1: register the raw samples and the window-close flag.
   always_ff @(posedge sample_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 3; i++) r_s1_smp[i] <= '0;
         r_s1_flag <= 1'b0;
      end else begin
         r_s1_smp[0] <= band1_in;
         r_s1_smp[1] <= band2_in;
         r_s1_smp[2] <= band3_in;
         r_s1_flag   <= set_values_flag;
      end
   end

   // Square via the magnitude; -2048 maps to 2048, which still fits 12 bits,
   // and the square (max 2^22) fits the 23-bit product exactly.
   always_comb begin
      for (int unsigned i = 0; i < 3; i++) begin
         w_mag[i] = r_s1_smp[i][11] ? (~r_s1_smp[i] + 12'd1) : r_s1_smp[i];
         w_sq[i]  = 23'(w_mag[i]) * 23'(w_mag[i]);
      end
   end

   // Stage 2: register the squares with the flag delayed alongside.
   always_ff @(posedge sample_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 3; i++) r_s2_sq[i] <= '0;
         r_s2_flag <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < 3; i++) r_s2_sq[i] <= w_sq[i];
         r_s2_flag <= r_s1_flag;
      end
   end

   // Saturating accumulate; the snapshot includes the square on the flag cycle.
   always_comb begin
      for (int unsigned i = 0; i < 3; i++) begin
         w_sum[i]      = {1'b0, r_acc[i]} + 41'(r_s2_sq[i]);
         w_acc_next[i] = w_sum[i][40] ? '1 : w_sum[i][39:0];
         w_shifted[i]  = w_acc_next[i] >> ACC_SHIFT;
         w_ms[i]       = (|w_shifted[i][39:24]) ? '1 : w_shifted[i][23:0];
      end
   end

   assign w_snap = r_s2_flag;

   // Stage 3: accumulators, cleared on the snapshot edge to start a new window.
   always_ff @(posedge sample_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 3; i++) r_acc[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < 3; i++) r_acc[i] <= w_snap ? '0 : w_acc_next[i];
      end
   end

   // Snapshot routing: load the working set when idle, otherwise park it in
   // the pending set; DONE consumes the old pending value before a new one lands.
   always_ff @(posedge sample_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 3; i++) begin
            r_work[i] <= '0;
            r_pend[i] <= '0;
         end
         r_pending <= 1'b0;
         r_overrun <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (r_pending) begin
                  r_work <= r_pend;
                  if (w_snap) r_pend    <= w_ms;
                  else        r_pending <= 1'b0;
               end else if (w_snap) begin
                  r_work <= w_ms;
               end
            end
            ST_DONE: begin
               if (r_pending) r_work <= r_pend;
               if (w_snap)    r_pend <= w_ms;
               r_pending <= w_snap;
            end
            default: begin
               if (w_snap) begin
                  r_pend    <= w_ms;
                  r_pending <= 1'b1;
                  if (r_pending && (r_overrun != 8'hFF)) r_overrun <= r_overrun + 8'd1;
               end
            end
         endcase
      end
   end

   // Digit-by-digit root step: (root + 2^b)^2 = root^2 + root*2^(b+1) + 2^(2b).
   always_comb begin
      case (r_band)
         2'd0:    w_cur_ms = r_work[0];
         2'd1:    w_cur_ms = r_work[1];
         default: w_cur_ms = r_work[2];
      endcase
      w_bit_mask    = 12'd1 << r_bit;
      w_trial_sq    = r_root_sq + (24'(r_root) << (r_bit + 4'd1)) + (24'd1 << {r_bit, 1'b0});
      w_take        = (w_trial_sq <= w_cur_ms);
      w_root_new    = w_take ? (r_root | w_bit_mask) : r_root;
      w_root_sq_new = w_take ? w_trial_sq : r_root_sq;
   end

   // FSM state register.
   always_ff @(posedge sample_clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   // FSM next state: IDLE -> SQRT on a snapshot, 36 SQRT cycles, then DONE.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_snap || r_pending) w_state_next = ST_SQRT;
         ST_SQRT: if ((r_band == 2'd2) && (r_bit == 4'd0)) w_state_next = ST_DONE;
         ST_DONE: w_state_next = r_pending ? ST_SQRT : ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Square-root engine: one result bit per cycle, MSB first, band by band.
   always_ff @(posedge sample_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_band    <= '0;
         r_bit     <= 4'd11;
         r_root    <= '0;
         r_root_sq <= '0;
         for (int unsigned i = 0; i < 3; i++) r_res[i] <= '0;
      end else if (r_state == ST_SQRT) begin
         if (r_bit == 4'd0) begin
            case (r_band)
               2'd0:    r_res[0] <= w_root_new;
               2'd1:    r_res[1] <= w_root_new;
               default: r_res[2] <= w_root_new;
            endcase
            r_band    <= r_band + 2'd1;
            r_bit     <= 4'd11;
            r_root    <= '0;
            r_root_sq <= '0;
         end else begin
            r_bit     <= r_bit - 4'd1;
            r_root    <= w_root_new;
            r_root_sq <= w_root_sq_new;
         end
      end else begin
         r_band    <= '0;
         r_bit     <= 4'd11;
         r_root    <= '0;
         r_root_sq <= '0;
      end
   end

   // Output registers: all three bars update together with the valid pulse.
   always_ff @(posedge sample_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 3; i++) r_bin[i] <= '0;
         r_vv <= 1'b0;
      end else begin
         r_vv <= (r_state == ST_DONE);
         if (r_state == ST_DONE) r_bin <= r_res;
      end
   end

   assign bin1_out     = r_bin[0];
   assign bin2_out     = r_bin[1];
   assign bin3_out     = r_bin[2];
   assign values_valid = r_vv;
   assign busy         = (r_state != ST_IDLE);
   assign overrun_cnt  = r_overrun;

endmodule

// File: tb/tb_band_power_calc.sv
// Scoreboard bench for band_power_calc: stimulus pushes hand-computed results,
// per-DUT monitors pop and compare whenever values_valid pulses.
module tb_band_power_calc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] b1, b2, b3;
   logic        flag;
   logic [11:0] o1, o2, o3;
   logic        vv, busy;
   logic [7:0]  ov;

   logic [11:0] z_b1, z_b2, z_b3;
   logic        z_flag;
   logic [11:0] zo1, zo2, zo3;
   logic        z_vv, z_busy;
   logic [7:0]  z_ov;

   int cyc     = 0;
   int n_tests = 0;
   int n_fail  = 0;
   int n_vv    = 0;
   int n_zvv   = 0;
   int n_push  = 0;
   int n_zpush = 0;

   typedef struct {
      logic [11:0] e1, e2, e3;
      logic [7:0]  eov;
      int          t;
   } exp_t;

   exp_t q_main[$];
   exp_t q_z[$];
   exp_t m_e;
   exp_t z_e;

   band_power_calc #(.ACC_SHIFT(12)) u_dut (
      .sample_clk(clk), .rst_n(rst_n),
      .band1_in(b1), .band2_in(b2), .band3_in(b3),
      .set_values_flag(flag),
      .bin1_out(o1), .bin2_out(o2), .bin3_out(o3),
      .values_valid(vv), .busy(busy), .overrun_cnt(ov)
   );

   band_power_calc #(.ACC_SHIFT(0)) u_dut_z (
      .sample_clk(clk), .rst_n(rst_n),
      .band1_in(z_b1), .band2_in(z_b2), .band3_in(z_b3),
      .set_values_flag(z_flag),
      .bin1_out(zo1), .bin2_out(zo2), .bin3_out(zo3),
      .values_valid(z_vv), .busy(z_busy), .overrun_cnt(z_ov)
   );

   always #5 clk = ~clk;

   // Edge counter: after posedge number k, cyc reads k at the following negedge.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_main(input int e1, input int e2, input int e3, input int eov, input int t);
      exp_t x;
      x.e1 = 12'(e1); x.e2 = 12'(e2); x.e3 = 12'(e3); x.eov = 8'(eov); x.t = t;
      q_main.push_back(x);
      n_push++;
   endtask

   task automatic push_z(input int e1, input int e2, input int e3, input int t);
      exp_t x;
      x.e1 = 12'(e1); x.e2 = 12'(e2); x.e3 = 12'(e3); x.eov = 8'd0; x.t = t;
      q_z.push_back(x);
      n_zpush++;
   endtask

   // Main DUT monitor.
   always @(negedge clk) begin
      if (vv) begin
         n_vv++;
         if (q_main.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_vv: values_valid=1 at cycle %0d, required 0", cyc);
         end else begin
            m_e = q_main.pop_front();
            check("bin1", int'(o1), int'(m_e.e1));
            check("bin2", int'(o2), int'(m_e.e2));
            check("bin3", int'(o3), int'(m_e.e3));
            check("overrun_cnt", int'(ov), int'(m_e.eov));
            check("vv_cycle", cyc, m_e.t);
         end
      end
   end

   // ACC_SHIFT=0 DUT monitor.
   always @(negedge clk) begin
      if (z_vv) begin
         n_zvv++;
         if (q_z.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_z_vv: values_valid=1 at cycle %0d, required 0", cyc);
         end else begin
            z_e = q_z.pop_front();
            check("z_bin1", int'(zo1), int'(z_e.e1));
            check("z_bin2", int'(zo2), int'(z_e.e2));
            check("z_bin3", int'(zo3), int'(z_e.e3));
            check("z_vv_cycle", cyc, z_e.t);
         end
      end
   end

   // Hold values for n samples with the flag low (entered and left at negedge).
   task automatic drive(input int n, input int v1, input int v2, input int v3);
      b1 = 12'(v1); b2 = 12'(v2); b3 = 12'(v3);
      flag = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // One flagged sample; e is the edge that sampled the flag.
   task automatic pulse(input int v1, input int v2, input int v3, output int e);
      b1 = 12'(v1); b2 = 12'(v2); b3 = 12'(v3);
      flag = 1'b1;
      @(negedge clk);
      flag = 1'b0;
      e = cyc;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((q_main.size() != 0 || q_z.size() != 0) && k < 300) begin
         @(negedge clk);
         k++;
      end
      n_tests++;
      if (q_main.size() != 0 || q_z.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d main and %0d aux results outstanding, required 0",
                  q_main.size(), q_z.size());
      end
   endtask

   initial begin
      int e, e0, e1, e2, nv;

      // Reset with random inputs.
      rst_n = 1'b0;
      flag = 1'b0; z_flag = 1'b0;
      b1 = '0; b2 = '0; b3 = '0;
      z_b1 = '0; z_b2 = '0; z_b3 = '0;
      repeat (6) begin
         b1 = 12'($urandom); b2 = 12'($urandom); b3 = 12'($urandom);
         flag = 1'($urandom); z_flag = 1'($urandom); z_b1 = 12'($urandom);
         @(negedge clk);
      end
      check("rst_bin1", int'(o1), 0);
      check("rst_bin2", int'(o2), 0);
      check("rst_bin3", int'(o3), 0);
      check("rst_vv", int'(vv), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_overrun", int'(ov), 0);
      check("rst_z_bin1", int'(zo1), 0);
      check("rst_z_busy", int'(z_busy), 0);
      check("rst_z_overrun", int'(z_ov), 0);

      // Release, random samples, no flag: no result may appear.
      flag = 1'b0; z_flag = 1'b0; z_b1 = '0;
      rst_n = 1'b1;
      repeat (10000) begin
         b1 = 12'($urandom); b2 = 12'($urandom); b3 = 12'($urandom);
         @(negedge clk);
      end
      check("idle_vv_count", n_vv, 0);
      check("idle_busy", int'(busy), 0);

      // Fresh reset, then a 4096-sample nominal window.
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      drive(4095, 1000, 0, -1000);
      pulse(1000, 0, -1000, e);
      push_main(1000, 0, 1000, 0, e + 39);
      drive(0, -2048, -2048, -2048);
      @(negedge clk);
      check("busy_E+2", int'(busy), 0);
      @(negedge clk);
      check("busy_E+3", int'(busy), 1);
      repeat (36) @(negedge clk);
      check("busy_E+39", int'(busy), 1);
      @(negedge clk);
      check("busy_E+40", int'(busy), 0);

      // Saturation: 20000 samples of -2048, then an 8192-sample window.
      drive(20000 - 40, -2048, -2048, -2048);
      pulse(-2048, -2048, -2048, e);
      push_main(4095, 4095, 4095, 0, e + 39);
      drive(8191, -2048, -2048, -2048);
      pulse(-2048, -2048, -2048, e);
      push_main(2896, 2896, 2896, 0, e + 39);

      // Pending and overrun: flags at e0, e0+10, e0+20.
      drive(4095, 2047, -1, 64);
      pulse(2047, -1, 64, e0);
      push_main(2047, 1, 64, 1, e0 + 39);
      drive(9, 2047, -2048, 640);
      pulse(2047, -2048, 640, e1);
      check("flag2_spacing", e1 - e0, 10);
      drive(9, 2047, -2048, 640);
      pulse(2047, -2048, 640, e2);
      push_main(101, 101, 31, 1, e0 + 76);
      drain();

      // Reset in the middle of a computation.
      drive(100, 300, 300, 300);
      pulse(300, 300, 300, e);
      repeat (19) @(negedge clk);
      nv = n_vv;
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_bin1", int'(o1), 0);
      check("midrst_bin3", int'(o3), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_overrun", int'(ov), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      drive(4095, 500, -500, 500);
      check("midrst_no_vv", n_vv, nv);
      pulse(500, -500, 500, e);
      push_main(500, 500, 500, 0, e + 39);
      drain();

      // Window boundary on the ACC_SHIFT=0 instance.
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      drive(100, 0, 0, 0);
      z_b1 = 12'd2000;
      z_flag = 1'b1;
      @(negedge clk);
      z_flag = 1'b0;
      z_b1 = '0;
      push_z(2000, 0, 0, cyc + 39);
      repeat (60) @(negedge clk);
      z_flag = 1'b1;
      @(negedge clk);
      z_flag = 1'b0;
      push_z(0, 0, 0, cyc + 39);
      drain();

      check("vv_count", n_vv, n_push);
      check("z_vv_count", n_zvv, n_zpush);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
